// File: rtl/snoop_initiator.sv
// Snoop initiator: one AC snoop, its CR response and an optional CD line; CR timeout via SNOOP_INITIATOR_TIMEOUT_EN.
// Latency: accept to rsp_valid is 3 cycles without data, 3+CD_BEATS with data (zero-wait peers).
// Backpressure: one snoop in flight; AC and rsp hold stable until ready; CR and CD are always ready in their states.
module snoop_initiator #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CRRESP_WIDTH   = 5,
    parameter int AW_LEN         = 3,
    parameter int CD_BEATS       = AW_LEN + 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    input  logic                           req_unique,
    output logic                           ac_valid,
    input  logic                           ac_ready,
    output logic [ADDR_WIDTH-1:0]          ac_addr,
    output logic [3:0]                     ac_snoop,
    output logic [2:0]                     ac_prot,
    input  logic                           cr_valid,
    output logic                           cr_ready,
    input  logic [CRRESP_WIDTH-1:0]        cr_resp,
    input  logic                           cd_valid,
    output logic                           cd_ready,
    input  logic [DATA_WIDTH-1:0]          cd_data,
    input  logic                           cd_last,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic                           rsp_has_data,
    output logic                           rsp_dirty,
    output logic                           rsp_shared,
    output logic                           rsp_err,
    output logic                           rsp_timeout,
    output logic [CD_BEATS*DATA_WIDTH-1:0] rsp_data
);
    localparam int CNT_W = $clog2(CD_BEATS + 1);

    typedef enum logic [2:0] {IDLE, SEND_AC, WAIT_CR, RECV_CD, RESPOND} state_t;

    typedef struct packed {
        logic has_data;
        logic dirty;
        logic shared;
        logic err;
    } flags_t;

    state_t                        state_q, state_d;
    logic [ADDR_WIDTH-1:0]         ac_addr_q, ac_addr_d;
    logic [3:0]                    ac_snoop_q, ac_snoop_d;
    flags_t                        flags_q, flags_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [CD_BEATS*DATA_WIDTH-1:0] data_q, data_d;
    logic                          cr_unused;

`ifdef SNOOP_INITIATOR_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_q, to_d;
    logic            timeout_q, timeout_d;
`endif

    assign cr_unused = ^cr_resp;

    always_comb begin
        state_d    = state_q;
        ac_addr_d  = ac_addr_q;
        ac_snoop_d = ac_snoop_q;
        flags_d    = flags_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
`ifdef SNOOP_INITIATOR_TIMEOUT_EN
        to_d       = to_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    ac_addr_d  = req_addr;
                    ac_snoop_d = req_unique ? 4'b0111 : 4'b0010;
                    flags_d    = '0;
                    cnt_d      = '0;
                    data_d     = '0;
`ifdef SNOOP_INITIATOR_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                    state_d    = SEND_AC;
                end
            end
            SEND_AC: begin
                if (ac_ready) begin
`ifdef SNOOP_INITIATOR_TIMEOUT_EN
                    to_d = '0;
`endif
                    state_d = WAIT_CR;
                end
            end
            WAIT_CR: begin
                // A CR arriving on the last allowed cycle beats the timeout
                if (cr_valid) begin
                    flags_d.has_data = cr_resp[0];
                    flags_d.dirty    = cr_resp[2];
                    flags_d.shared   = cr_resp[3];
                    flags_d.err      = 1'b0;
                    cnt_d            = '0;
`ifdef SNOOP_INITIATOR_TIMEOUT_EN
                    timeout_d        = 1'b0;
`endif
                    state_d          = cr_resp[0] ? RECV_CD : RESPOND;
                end
`ifdef SNOOP_INITIATOR_TIMEOUT_EN
                else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    flags_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = RESPOND;
                end else begin
                    to_d = to_q + 1'b1;
                end
`endif
            end
            RECV_CD: begin
                if (cd_valid) begin
                    // Surplus beats are drained; the counter saturates at CD_BEATS
                    if (cnt_q < CNT_W'(CD_BEATS)) begin
                        data_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = cd_data;
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cd_last) begin
                        flags_d.err = (cnt_q != CNT_W'(CD_BEATS - 1));
                        state_d     = RESPOND;
                    end
                end
            end
            RESPOND: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            ac_addr_q  <= '0;
            ac_snoop_q <= '0;
            flags_q    <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
`ifdef SNOOP_INITIATOR_TIMEOUT_EN
            to_q       <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ac_addr_q  <= ac_addr_d;
            ac_snoop_q <= ac_snoop_d;
            flags_q    <= flags_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
`ifdef SNOOP_INITIATOR_TIMEOUT_EN
            to_q       <= to_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign ac_valid     = (state_q == SEND_AC);
    assign cr_ready     = (state_q == WAIT_CR);
    assign cd_ready     = (state_q == RECV_CD);
    assign rsp_valid    = (state_q == RESPOND);
    assign ac_addr      = ac_addr_q;
    assign ac_snoop     = ac_snoop_q;
    assign ac_prot      = 3'b000;
    assign rsp_has_data = flags_q.has_data;
    assign rsp_dirty    = flags_q.dirty;
    assign rsp_shared   = flags_q.shared;
    assign rsp_err      = flags_q.err;
    assign rsp_data     = data_q;
`ifdef SNOOP_INITIATOR_TIMEOUT_EN
    assign rsp_timeout  = timeout_q;
`else
    assign rsp_timeout  = 1'b0;
`endif

endmodule
